// File: rtl/dec_gray2bin_seq.sv
// Bit-serial Gray-to-binary decoder: one bit per clock, MSB first, with a
// valid/ready handshake on both sides and the result held until it is consumed.
//
// state | meaning
// IDLE  | waiting for a word; in_ready high, last result kept on out_bin
// SHIFT | decoding one bit per clock from WIDTH-1 down to 0
// HOLD  | result presented with out_valid until out_ready
module dec_gray2bin_seq #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_out;
    logic [IW-1:0]    r_idx;
    logic             r_prev;
    logic             w_bit;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_last;

    assign w_bit  = r_prev ^ r_gray[r_idx];
    assign w_last = (r_idx == '0);

    always_comb begin
        w_acc_nxt        = r_acc;
        w_acc_nxt[r_idx] = w_bit;
    end

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = in_valid ? SHIFT : IDLE;
            SHIFT:   w_state_nxt = w_last ? HOLD : SHIFT;
            HOLD:    w_state_nxt = out_ready ? IDLE : HOLD;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gray <= '0;
            r_acc  <= '0;
            r_out  <= '0;
            r_idx  <= '0;
            r_prev <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_gray <= in_gray;
                        r_acc  <= '0;
                        r_prev <= 1'b0;
                        r_idx  <= IW'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    r_acc  <= w_acc_nxt;
                    r_prev <= w_bit;
                    r_idx  <= r_idx - IW'(1);
                    // Only the completed word ever reaches the output register.
                    if (w_last) begin
                        r_out <= w_acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign busy      = (r_state == SHIFT) || (r_state == HOLD);
    assign out_bin   = r_out;

endmodule
